// File: rtl/lcd_pkg.sv
// Shared definitions for the LT24 frame sequencer: frame modes, colours,
// display geometry, sequencer state encoding and a window span helper.
package lcd_pkg;

  localparam int LCD_WIDTH  = 240;
  localparam int LCD_HEIGHT = 320;

  localparam logic [1:0] MODE_SOLID  = 2'd0;
  localparam logic [1:0] MODE_ROM    = 2'd1;
  localparam logic [1:0] MODE_WINDOW = 2'd2;

  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] YELLOW = 16'hFFE0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PIXEL = 3'd1,
    ST_FETCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // True when start <= pos < start+len. Operands are 10 bits wide so that
  // start+len (at most 511+511) never wraps.
  function automatic logic in_span(input logic [9:0] pos,
                                   input logic [9:0] start,
                                   input logic [9:0] len);
    return (pos >= start) && (pos < (start + len));
  endfunction

endpackage

// File: rtl/lcd_raster_counter.sv
// Raster position counter: x runs fastest, wraps at WIDTH-1 and carries
// into y; last_pixel flags the bottom-right pixel of the frame.
module lcd_raster_counter #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic       clock,
  input  logic       resetApp,
  input  logic       clear,
  input  logic       advance,
  output logic [7:0] x_count,
  output logic [8:0] y_count,
  output logic       last_pixel
);

  logic [7:0] x_r;
  logic [8:0] y_r;
  logic       x_last_s;
  logic       y_last_s;

  assign x_last_s   = (x_r == 8'(WIDTH - 1));
  assign y_last_s   = (y_r == 9'(HEIGHT - 1));
  assign last_pixel = x_last_s && y_last_s;
  assign x_count    = x_r;
  assign y_count    = y_r;

  // Position register: clear to the origin, or step one pixel on advance.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      x_r <= 8'd0;
      y_r <= 9'd0;
    end else if (clear) begin
      x_r <= 8'd0;
      y_r <= 9'd0;
    end else if (advance) begin
      if (x_last_s) begin
        x_r <= 8'd0;
        y_r <= y_last_s ? 9'd0 : (y_r + 9'd1);
      end else begin
        x_r <= x_r + 8'd1;
      end
    end else begin
      x_r <= x_r;
      y_r <= y_r;
    end
  end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Full-frame redraw sequencer for the LT24 pixel interface. Each pixel is
// either the latched fill colour or an image ROM word, written in raster
// order with a ready/valid handshake toward LT24Display.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int WIDTH       = LCD_WIDTH,
  parameter int HEIGHT      = LCD_HEIGHT,
  parameter int ROM_AW      = 17,
  parameter int ROM_LATENCY = 2
) (
  input  logic              clock,
  input  logic              resetApp,
  input  logic              frameReq,
  input  logic [1:0]        frameMode,
  input  logic [15:0]       fillColour,
  input  logic [7:0]        winX0,
  input  logic [8:0]        winY0,
  input  logic [7:0]        winW,
  input  logic [8:0]        winH,
  output logic              frameBusy,
  output logic              frameDone,
  output logic [ROM_AW-1:0] romAddr,
  input  logic [15:0]       romQ,
  output logic [7:0]        xAddr,
  output logic [8:0]        yAddr,
  output logic [15:0]       pixelData,
  output logic              pixelWrite,
  input  logic              pixelReady
);

  seq_state_t        state_r;
  logic [1:0]        mode_r;
  logic [15:0]       fill_r;
  logic [7:0]        win_x0_r;
  logic [8:0]        win_y0_r;
  logic [7:0]        win_w_r;
  logic [8:0]        win_h_r;
  logic [7:0]        lat_r;

  logic [7:0]        x_s;
  logic [8:0]        y_s;
  logic              last_s;
  logic              accept_s;
  logic              advance_s;
  logic              in_win_s;
  logic              rom_pix_s;
  logic [ROM_AW-1:0] lin_addr_s;
  logic [ROM_AW-1:0] win_addr_s;
  logic [ROM_AW-1:0] rom_addr_s;

  assign accept_s  = (state_r == ST_IDLE) && frameReq;
  assign advance_s = (state_r == ST_WRITE) && pixelReady;
  assign xAddr     = x_s;
  assign yAddr     = y_s;

  lcd_raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clock      (clock),
    .resetApp   (resetApp),
    .clear      (accept_s),
    .advance    (advance_s),
    .x_count    (x_s),
    .y_count    (y_s),
    .last_pixel (last_s)
  );

  // Classify the current pixel and form both candidate ROM addresses.
  always_comb begin
    in_win_s   = in_span({2'b00, x_s}, {2'b00, win_x0_r}, {2'b00, win_w_r}) &&
                 in_span({1'b0, y_s}, {1'b0, win_y0_r}, {1'b0, win_h_r});
    lin_addr_s = ROM_AW'(y_s) * ROM_AW'(WIDTH) + ROM_AW'(x_s);
    win_addr_s = ROM_AW'(y_s - win_y0_r) * ROM_AW'(win_w_r) + ROM_AW'(x_s - win_x0_r);
    rom_pix_s  = 1'b0;
    rom_addr_s = lin_addr_s;
    case (mode_r)
      MODE_ROM: begin
        rom_pix_s  = 1'b1;
        rom_addr_s = lin_addr_s;
      end
      MODE_WINDOW: begin
        rom_pix_s  = in_win_s;
        rom_addr_s = win_addr_s;
      end
      default: begin
        rom_pix_s  = 1'b0;
        rom_addr_s = lin_addr_s;
      end
    endcase
  end

  // Frame sequencer FSM with registered handshake, status and ROM outputs.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state_r    <= ST_IDLE;
      mode_r     <= 2'd0;
      fill_r     <= 16'd0;
      win_x0_r   <= 8'd0;
      win_y0_r   <= 9'd0;
      win_w_r    <= 8'd0;
      win_h_r    <= 9'd0;
      lat_r      <= 8'd0;
      frameBusy  <= 1'b0;
      frameDone  <= 1'b0;
      romAddr    <= {ROM_AW{1'b0}};
      pixelData  <= 16'd0;
      pixelWrite <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          frameDone <= 1'b0;
          if (frameReq) begin
            mode_r    <= frameMode;
            fill_r    <= fillColour;
            win_x0_r  <= winX0;
            win_y0_r  <= winY0;
            win_w_r   <= winW;
            win_h_r   <= winH;
            frameBusy <= 1'b1;
            state_r   <= ST_PIXEL;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_PIXEL: begin
          if (rom_pix_s) begin
            romAddr <= rom_addr_s;
            lat_r   <= 8'(ROM_LATENCY - 1);
            state_r <= ST_FETCH;
          end else begin
            pixelData  <= fill_r;
            pixelWrite <= 1'b1;
            state_r    <= ST_WRITE;
          end
        end
        ST_FETCH: begin
          if (lat_r == 8'd0) begin
            pixelData  <= romQ;
            pixelWrite <= 1'b1;
            state_r    <= ST_WRITE;
          end else begin
            lat_r <= lat_r - 8'd1;
          end
        end
        ST_WRITE: begin
          if (pixelReady) begin
            pixelWrite <= 1'b0;
            if (last_s) begin
              frameDone <= 1'b1;
              frameBusy <= 1'b0;
              state_r   <= ST_DONE;
            end else begin
              state_r   <= ST_PIXEL;
            end
          end else begin
            state_r <= ST_WRITE;
          end
        end
        ST_DONE: begin
          frameDone <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          frameBusy  <= 1'b0;
          frameDone  <= 1'b0;
          pixelWrite <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench for lcd_frame_sequencer on a 16x12 display with a
// registered image ROM (latency 2) that returns its own address.
module tb_lcd_frame_sequencer;
  import lcd_pkg::*;

  localparam int W    = 16;
  localparam int H    = 12;
  localparam int NPIX = W * H;

  logic        clock = 1'b0;
  logic        resetApp, frameReq, pixelReady;
  logic [1:0]  frameMode;
  logic [15:0] fillColour;
  logic [7:0]  winX0, winW;
  logic [8:0]  winY0, winH;
  logic        frameBusy, frameDone, pixelWrite;
  logic [16:0] romAddr;
  logic [15:0] romQ = 16'h0000;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;

  always #5 clock = ~clock;

  lcd_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .ROM_AW(17), .ROM_LATENCY(2)) dut (
    .clock(clock), .resetApp(resetApp), .frameReq(frameReq), .frameMode(frameMode),
    .fillColour(fillColour), .winX0(winX0), .winY0(winY0), .winW(winW), .winH(winH),
    .frameBusy(frameBusy), .frameDone(frameDone), .romAddr(romAddr), .romQ(romQ),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite),
    .pixelReady(pixelReady)
  );

  // Image ROM model: one register stage, data equals address.
  always @(posedge clock) romQ <= romAddr[15:0];

  // Pixel monitor: records accepted pixels, frameDone pulses and stall violations.
  logic [7:0]  cap_x [0:4095];
  logic [8:0]  cap_y [0:4095];
  logic [15:0] cap_d [0:4095];
  int cap_total = 0, done_total = 0, stall_err = 0;
  logic        st_prev = 1'b0;
  logic [7:0]  st_x;
  logic [8:0]  st_y;
  logic [15:0] st_d;
  always @(negedge clock) begin
    if (resetApp) begin
      st_prev <= 1'b0;
    end else begin
      if (st_prev && (!pixelWrite || xAddr != st_x || yAddr != st_y || pixelData != st_d))
        stall_err <= stall_err + 1;
      if (pixelWrite && pixelReady) begin
        cap_x[cap_total] <= xAddr;
        cap_y[cap_total] <= yAddr;
        cap_d[cap_total] <= pixelData;
        cap_total <= cap_total + 1;
      end
      if (frameDone) done_total <= done_total + 1;
      st_prev <= pixelWrite && !pixelReady;
      st_x <= xAddr;
      st_y <= yAddr;
      st_d <= pixelData;
    end
  end

  int n_checks = 0, n_pass = 0;
  int cfg_mode, cfg_wx, cfg_wy, cfg_ww, cfg_wh;
  logic [15:0] cfg_fill;
  logic rdy_random = 1'b0;
  int last_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_pix(input int idx);
    int x, y;
    x = idx % W;
    y = idx / W;
    if (cfg_mode == 1) return 16'(y * W + x);
    if (cfg_mode == 2 && x >= cfg_wx && x < cfg_wx + cfg_ww && y >= cfg_wy && y < cfg_wy + cfg_wh)
      return 16'((y - cfg_wy) * cfg_ww + (x - cfg_wx));
    return cfg_fill;
  endfunction

  // Wait for frameDone, optionally pulsing frameReq at cycle poke and driving random ready.
  task automatic wait_done(input int poke, output int cyc);
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clock);
      cyc++;
      #1;
      if (poke >= 0) frameReq = (cyc == poke);
      if (rdy_random) pixelReady = (cyc >= 100 && cyc < 110) ? 1'b0 : 1'($urandom_range(0, 1));
      if (frameDone) break;
    end
    chk("done_seen", {31'd0, frameDone}, 32'd1);
  endtask

  task automatic run_frame(input string tag, input int mode, input logic [15:0] fill,
                           input int wx, input int wy, input int ww, input int wh,
                           input int poke, input int exp_cyc);
    int cyc, bad, base_done, base_stall, idx;
    cfg_mode = mode; cfg_fill = fill; cfg_wx = wx; cfg_wy = wy; cfg_ww = ww; cfg_wh = wh;
    frameMode = 2'(mode); fillColour = fill;
    winX0 = 8'(wx); winY0 = 9'(wy); winW = 8'(ww); winH = 9'(wh);
    last_base = cap_total; base_done = done_total; base_stall = stall_err;
    frameReq = 1'b1;
    @(posedge clock); #1;
    frameReq = 1'b0;
    fillColour = ~fill; frameMode = 2'(mode) ^ 2'd1;
    winX0 = winX0 + 8'd1; winW = winW + 8'd3; winH = winH + 9'd2;
    wait_done(poke, cyc);
    if (exp_cyc > 0) chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    rdy_random = 1'b0; pixelReady = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk({tag, "_busy_after"}, {31'd0, frameBusy}, 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_total - base_done), 32'd1);
    chk({tag, "_pixel_count"}, 32'(cap_total - last_base), 32'(NPIX));
    chk({tag, "_stall_stable"}, 32'(stall_err - base_stall), 32'd0);
    bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      idx = last_base + i;
      if (cap_x[idx] != 8'(i % W) || cap_y[idx] != 9'(i / W) || cap_d[idx] != exp_pix(i)) bad++;
    end
    chk({tag, "_bad_pixels"}, 32'(bad), 32'd0);
  endtask

  int cyc, base_done;

  initial begin
    resetApp = 1'b1; frameReq = 1'b0; pixelReady = 1'b1; frameMode = 2'd0;
    fillColour = 16'h0000; winX0 = 8'd0; winY0 = 9'd0; winW = 8'd0; winH = 9'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {7'd0, frameBusy, frameDone, pixelWrite, xAddr, yAddr, pixelData[11:0]}, 32'd0);
    chk("reset_rom_data", {15'd0, romAddr}, 32'd0);
    resetApp = 1'b0;
    @(posedge clock); #1;

    run_frame("solid", 0, 16'hF920, 0, 0, 0, 0, -1, 2 * NPIX);
    run_frame("rom", 1, BLACK, 0, 0, 0, 0, -1, 4 * NPIX);
    chk("rom_px_2_1", {16'd0, cap_d[last_base + 18]}, 32'd18);
    chk("rom_px_last", {16'd0, cap_d[last_base + 191]}, 32'd191);

    run_frame("window", 2, BLUE, 3, 2, 5, 4, -1, 20 * 4 + (NPIX - 20) * 2);
    chk("win_first", {16'd0, cap_d[last_base + 35]}, 32'd0);
    chk("win_last", {16'd0, cap_d[last_base + 87]}, 32'd19);
    chk("win_right_out", {16'd0, cap_d[last_base + 88]}, {16'd0, BLUE});
    chk("win_left_out", {16'd0, cap_d[last_base + 34]}, {16'd0, BLUE});

    run_frame("win_empty", 2, GREEN, 3, 2, 0, 4, 40, 2 * NPIX);
    run_frame("win_clip", 2, RED, 12, 0, 20, 12, -1, 48 * 4 + (NPIX - 48) * 2);
    chk("clip_first", {16'd0, cap_d[last_base + 12]}, 32'd0);
    chk("clip_corner", {16'd0, cap_d[last_base + 191]}, 32'd223);
    chk("clip_outside", {16'd0, cap_d[last_base + 11]}, {16'd0, RED});
    run_frame("mode3", 3, YELLOW, 0, 0, 8, 8, -1, 2 * NPIX);

    rdy_random = 1'b1;
    run_frame("backpressure", 1, BLACK, 0, 0, 0, 0, -1, 0);

    // frameReq held high: second frame accepted on the IDLE cycle after DONE.
    cfg_mode = 0; cfg_fill = GREEN;
    frameMode = 2'd0; fillColour = GREEN;
    base_done = done_total;
    frameReq = 1'b1;
    @(posedge clock); #1;
    wait_done(-1, cyc);
    chk("held_first_cycles", 32'(cyc), 32'(2 * NPIX));
    @(posedge clock); #1;
    chk("held_gap_idle", {31'd0, frameBusy}, 32'd0);
    @(posedge clock); #1;
    chk("held_restart", {31'd0, frameBusy}, 32'd1);
    frameReq = 1'b0;
    wait_done(-1, cyc);
    chk("held_second_cycles", 32'(cyc), 32'(2 * NPIX));
    @(posedge clock); #1;
    chk("held_done_pulses", 32'(done_total - base_done), 32'd2);

    // Reset mid-frame abandons the frame without frameDone.
    base_done = done_total;
    frameMode = 2'd1; frameReq = 1'b1;
    @(posedge clock); #1;
    frameReq = 1'b0;
    repeat (50) @(posedge clock);
    #1;
    chk("midframe_active", {31'd0, frameBusy}, 32'd1);
    resetApp = 1'b1;
    #1;
    chk("midframe_reset_outputs", {7'd0, frameBusy, frameDone, pixelWrite, xAddr, yAddr, pixelData[11:0]}, 32'd0);
    chk("midframe_reset_rom", {15'd0, romAddr}, 32'd0);
    repeat (4) @(posedge clock);
    #1;
    resetApp = 1'b0;
    @(posedge clock); #1;
    chk("midframe_no_done", 32'(done_total - base_done), 32'd0);
    run_frame("after_reset", 0, RED, 0, 0, 0, 0, -1, 2 * NPIX);
    chk("after_reset_origin", {15'd0, cap_x[last_base], cap_y[last_base]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_frame_sequencer.md
Name: lcd_frame_sequencer

Overview:
- Sequences one full-frame redraw of the LT24 display through the LT24Display pixel interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady).
- On a frame request it scans every pixel in raster order, x fastest.
- Each pixel's colour comes from a solid fill colour, a full-screen image ROM, or a ROM window drawn over the fill colour.
- It takes over the free-running counter and always-write scheme in game logic, so game states only request screens and wait for frameDone.

Parameters:
- WIDTH, 240, display width in pixels.
- HEIGHT, 320, display height in pixels.
- ROM_AW, 17, ROM address width.
- ROM_LATENCY, 2, cycles from romAddr update to romQ valid (min 1).

Ports:
- clock  in  1  system clock.
- resetApp  in  1  asynchronous active-high reset.
- frameReq  in  1  request a frame; sampled only in IDLE.
- frameMode  in  2  0=solid, 1=full ROM, 2=windowed ROM, 3=solid (reserved).
- fillColour  in  16  RGB565 fill colour; also used outside the window in mode 2.
- winX0  in  8  window left column, inclusive.
- winY0  in  9  window top row, inclusive.
- winW  in  8  window width; 0 means no window.
- winH  in  9  window height.
- frameBusy  out  1  high from request accept until frameDone.
- frameDone  out  1  one-cycle pulse after the last pixel is accepted.
- romAddr  out  ROM_AW  shared image ROM address.
- romQ  in  16  ROM data.
- xAddr  out  8  pixel column to LT24Display.
- yAddr  out  9  pixel row to LT24Display.
- pixelData  out  16  pixel colour to LT24Display.
- pixelWrite  out  1  pixel valid to LT24Display.
- pixelReady  in  1  LT24Display ready; a pixel is accepted on a cycle with pixelWrite && pixelReady.

Behaviour:
- Reset: all outputs 0, state IDLE. Asynchronous, effective mid-frame: the frame is abandoned with no frameDone.
- Request latch: in IDLE, frameReq=1 latches frameMode, fillColour and the window registers, sets x=y=0, then goes to PIXEL. Inputs may change after acceptance without effect.
- Ignored requests: frameReq in any other state is ignored and not queued.
- States: IDLE, PIXEL, FETCH, WRITE, DONE.
- PIXEL: classifies the current pixel.
  - Mode 1: ROM pixel.
  - Mode 2: ROM pixel if winX0<=x<winX0+winW and winY0<=y<winY0+winH. Compare at 10 bits so the sum cannot wrap.
  - ROM pixel: romAddr <= y*WIDTH+x (mode 1) or (y-winY0)*winW+(x-winX0) (mode 2), truncated to ROM_AW. Load latency counter, go to FETCH.
  - Otherwise: pixelData <= fillColour, go to WRITE.
- FETCH: counts ROM_LATENCY cycles, then pixelData <= romQ, go to WRITE. romAddr is held stable throughout.
- WRITE:
  - xAddr/yAddr/pixelData are stable and pixelWrite=1 until the first cycle with pixelReady=1.
  - pixelWrite may never drop before acceptance.
  - On acceptance: pixelWrite <= 0 and the raster advances.
  - If x==WIDTH-1, x wraps to 0 and y increments.
  - If also y==HEIGHT-1, go to DONE; else go to PIXEL.
- DONE: frameDone=1 for one cycle, frameBusy drops in the same cycle, next state IDLE. A request held high is accepted on the next IDLE cycle, so back-to-back frames have a 1-cycle gap.
- frameBusy: 1 in PIXEL, FETCH and WRITE.
- Throughput:
  - Fill pixel: 2 cycles minimum.
  - ROM pixel: ROM_LATENCY+2 cycles minimum.
  - Extra cycles follow pixelReady stalls.
- Window edge cases: winW=0 or winH=0 in mode 2 gives an all-fill frame. A window extending past the screen is clipped naturally.
- romAddr holds its last value outside FETCH.

Decomposition:
- Shared package lcd_pkg:
  - Frame mode constants MODE_SOLID, MODE_ROM, MODE_WINDOW.
  - Colour constants BLACK, GREEN, RED, BLUE, YELLOW.
  - LCD_WIDTH/LCD_HEIGHT.
  - State encoding.
- Sub-module lcd_raster_counter: x/y counter with advance input, wrap, and a lastPixel flag. Reuses UpCounterNbit semantics.

Test Plan:
- Solid fill: WIDTH=4, HEIGHT=3, mode 0, fillColour=16'hF920, pixelReady tied 1 → 12 writes in raster order, all 16'hF920. frameDone pulses once, 24 cycles after accept. frameBusy=0 afterwards.
- Full ROM: 4x3, mode 1, ROM model returns addr, ROM_LATENCY=2 → pixel (x=2, y=1) carries data 6. romAddr stable during each FETCH. 12 writes, 48 cycles.
- Window, default size: 240x320, mode 2, window (24,143,195,36), fill BLACK → only pixels in x 24..218, y 143..178 carry ROM data. Pixel (24,143) reads addr 0; pixel (218,178) reads addr 7019.
- Window, empty and clipped: winW=0 → all fill. winX0=230, winW=20 → ROM used only for x 230..239.
- Backpressure: pixelReady toggled randomly, held low 10 cycles mid-write → pixelWrite and data stable while stalled. No pixel lost or duplicated.
- Control corner cases:
  - frameReq pulsed while busy → ignored.
  - frameReq held high → second frame starts 1 cycle after frameDone.
  - resetApp asserted mid-frame → all outputs 0 immediately, no frameDone, next request restarts at (0,0).
